stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
Parametrised multi-cycle stage sequencer: next-generation replacement for the fixed 5-stage step counter inside the control signal generator. Drives the stage number (and one-hot form) used by the processor's control decode and the stage progress display. It adds what the fixed counter lacks: run/halt/single-step control, MFC wait states for instruction fetch and data memory, a wait timeout fault, and a retired-instruction counter.

Parameters:
NUM_STAGES, 5, stages per instruction (2..15); stages are numbered 1..NUM_STAGES, and 0 means halted.
STAGE_W, 4, width of Stage; must hold NUM_STAGES.
FETCH_STAGE, 1, stage that waits on Fetch_MFC.
MEM_STAGE, 4, stage that waits on Mem_MFC when Mem_Access=1.
MFC_TIMEOUT, 8, maximum wait cycles before fault; 0 disables the timeout.
TMO_W, 4, width of the internal wait counter.
COUNT_W, 16, width of Instr_Count.

Ports:
Clock  input  1  system clock; all state changes on the rising edge.
Reset  input  1  synchronous, active-high reset.
Run  input  1  level; continuous execution while high.
Step  input  1  one-cycle pulse; executes one instruction from halt.
Fetch_MFC  input  1  ROM memory-function-complete.
Mem_Access  input  1  current instruction accesses RAM (valid during MEM_STAGE).
Mem_MFC  input  1  RAM memory-function-complete.
Stage  output  STAGE_W  current stage: 0 = halted/fault, 1..NUM_STAGES otherwise.
Stage_OneHot  output  NUM_STAGES  bit s-1 set in stage s; all zero when Stage=0.
Stage_First  output  1  high in the first cycle of each stage.
Waiting  output  1  high while stalled on MFC.
Instr_Done  output  1  one-cycle pulse in the cycle after the last stage completes.
Instr_Count  output  COUNT_W  retired instructions; wraps modulo 2^COUNT_W.
Halted  output  1  high in HALT.
Fault  output  1  sticky; set on MFC timeout.

Behaviour:
- All outputs are registered, with no combinational input-to-output paths.
- Reset has priority over everything:
  - Stage=0, Stage_OneHot=0, Stage_First=0, Waiting=0, Instr_Done=0, Instr_Count=0, Fault=0, Halted=1.
  - FSM enters HALT and the wait counter clears.
- FSM states: HALT, EXEC, FAULT.
- HALT (Stage=0):
  - Run=1 -> EXEC stage 1 next cycle, continuous mode.
  - Otherwise Step=1 -> EXEC stage 1, single-step mode.
  - Run and Step both high: Run wins. Step outside HALT is ignored.
- EXEC, stage s; the stage advances on a cycle unless it is wait-eligible and the relevant MFC is low:
  - s==FETCH_STAGE is eligible on Fetch_MFC.
  - s==MEM_STAGE with Mem_Access=1 is eligible on Mem_MFC.
  - Mem_Access is sampled every cycle of MEM_STAGE.
  - MFC inputs are ignored outside eligible stages.
- No-wait latency is exactly NUM_STAGES cycles per instruction.
- Wait counter:
  - Clears on stage entry.
  - Increments each stalled cycle; Waiting=1 in those cycles.
  - If stalled and counter==MFC_TIMEOUT-1 (with MFC_TIMEOUT>0), next state is FAULT.
  - MFC arriving in that same cycle wins: the stage advances, no fault.
- Advance from s<NUM_STAGES: Stage=s+1 with Stage_First=1.
- Advance from NUM_STAGES:
  - Instr_Done pulses and Instr_Count increments (wraps from all-ones to 0).
  - Continuous mode with Run=1: go to stage 1.
  - Otherwise go to HALT.
- Run dropping mid-instruction: the current instruction completes, then HALT.
- Run raised during a single-step: switches to continuous at the end of that instruction.
- FAULT: Stage=0, Fault=1, Halted=0, Waiting=0. Only Reset exits FAULT.
- Stage_First is 1 on the first cycle of stage 1 after HALT and after every stage change. It is 0 while stalled and in HALT/FAULT.

Test Plan:
- Reset, then Run=1 with both MFCs tied high -> Stage sequence 1,2,3,4,5,1…; Instr_Done pulses every 5 cycles; Instr_Count=4 after 20 cycles.
- Halted, Step pulse with Run=0 -> Stage 1..5 once, Instr_Done once, Stage=0, Halted=1, Instr_Count=1; a second Step repeats this.
- Mem_Access=1, Mem_MFC low 3 cycles in stage 4, then high -> stage 4 lasts 4 cycles, Waiting=1 for 3, instruction takes 8 cycles.
- Fetch_MFC held low, MFC_TIMEOUT=8 -> stage 1 for 8 cycles, then Fault=1, Stage=0; Run toggles are ignored until Reset clears all outputs.
- Mem_MFC rises on the 8th stalled cycle -> advance to stage 5, Fault stays 0.
- Run drops in stage 2 -> stages 3,4,5 complete, Instr_Done, HALT; Reset asserted in stage 3 -> next cycle Stage=0, Instr_Count=0. Count from 16'hFFFF wraps to 0.

Source files
------------

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stage_sequencer
// Description : Multi-cycle stage sequencer with run/halt/single-step control,
//               MFC wait states on fetch and data-memory stages, a wait
//               timeout fault and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_sequencer #(
    parameter int NUM_STAGES  = 5,
    parameter int STAGE_W     = 4,
    parameter int FETCH_STAGE = 1,
    parameter int MEM_STAGE   = 4,
    parameter int MFC_TIMEOUT = 8,
    parameter int TMO_W       = 4,
    parameter int COUNT_W     = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Run,
    input  logic                  Step,
    input  logic                  Fetch_MFC,
    input  logic                  Mem_Access,
    input  logic                  Mem_MFC,
    output logic [STAGE_W-1:0]    Stage,
    output logic [NUM_STAGES-1:0] Stage_OneHot,
    output logic                  Stage_First,
    output logic                  Waiting,
    output logic                  Instr_Done,
    output logic [COUNT_W-1:0]    Instr_Count,
    output logic                  Halted,
    output logic                  Fault
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [STAGE_W-1:0] C_STAGE_ONE = STAGE_W'(1);
    localparam logic [STAGE_W-1:0] C_STAGE_LAST = STAGE_W'(NUM_STAGES);
    localparam logic [STAGE_W-1:0] C_FETCH = STAGE_W'(FETCH_STAGE);
    localparam logic [STAGE_W-1:0] C_MEM = STAGE_W'(MEM_STAGE);
    localparam bit C_TMO_EN = (MFC_TIMEOUT > 0);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(MFC_TIMEOUT > 0 ? MFC_TIMEOUT - 1 : 0);
    localparam logic [TMO_W-1:0] C_WCNT_MAX = {TMO_W{1'b1}};

    state_t                  state_q, state_d;
    logic [STAGE_W-1:0]      stage_q, stage_d;
    logic [NUM_STAGES-1:0]   onehot_q, onehot_d;
    logic [TMO_W-1:0]        wcnt_q, wcnt_d;
    logic [COUNT_W-1:0]      count_q, count_d;
    logic                    first_q, first_d;
    logic                    waiting_q, waiting_d;
    logic                    done_q, done_d;
    logic                    halted_q, halted_d;
    logic                    fault_q, fault_d;

    logic                    w_stall;
    logic                    w_timeout;

    // Stall and timeout detection for the current stage (MFCs only matter in eligible stages)
    always_comb begin
        w_stall = (state_q == ST_EXEC) &&
                  (((stage_q == C_FETCH) && !Fetch_MFC) ||
                   ((stage_q == C_MEM) && Mem_Access && !Mem_MFC));
        w_timeout = w_stall && C_TMO_EN && (wcnt_q == C_TMO_LAST);
    end

    // Next-state and next-output computation; every output is derived from next state
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        wcnt_d    = wcnt_q;
        count_d   = count_q;
        first_d   = 1'b0;
        waiting_d = 1'b0;
        done_d    = 1'b0;
        onehot_d  = '0;

        case (state_q)
            ST_HALT: begin
                stage_d = '0;
                if (Run || Step) begin
                    state_d = ST_EXEC;
                    stage_d = C_STAGE_ONE;
                    first_d = 1'b1;
                    wcnt_d  = '0;
                end
            end
            ST_EXEC: begin
                if (w_timeout) begin
                    state_d = ST_FAULT;
                    stage_d = '0;
                    wcnt_d  = '0;
                end else if (w_stall) begin
                    waiting_d = 1'b1;
                    // Saturate so a disabled timeout never wraps the counter
                    if (wcnt_q != C_WCNT_MAX) begin
                        wcnt_d = wcnt_q + TMO_W'(1);
                    end
                end else if (stage_q == C_STAGE_LAST) begin
                    done_d  = 1'b1;
                    count_d = count_q + COUNT_W'(1);
                    wcnt_d  = '0;
                    // Run sampled at the end of the instruction decides continue vs halt
                    if (Run) begin
                        stage_d = C_STAGE_ONE;
                        first_d = 1'b1;
                    end else begin
                        state_d = ST_HALT;
                        stage_d = '0;
                    end
                end else begin
                    stage_d = stage_q + STAGE_W'(1);
                    first_d = 1'b1;
                    wcnt_d  = '0;
                end
            end
            ST_FAULT: begin
                stage_d = '0;
                wcnt_d  = '0;
            end
            default: begin
                state_d = ST_HALT;
                stage_d = '0;
                wcnt_d  = '0;
            end
        endcase

        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_d == STAGE_W'(i + 1)) begin
                onehot_d[i] = 1'b1;
            end
        end

        halted_d = (state_d == ST_HALT);
        fault_d  = (state_d == ST_FAULT);
    end

    // State and registered outputs; reset takes priority over all activity
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_HALT;
            stage_q   <= '0;
            onehot_q  <= '0;
            wcnt_q    <= '0;
            count_q   <= '0;
            first_q   <= 1'b0;
            waiting_q <= 1'b0;
            done_q    <= 1'b0;
            halted_q  <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            onehot_q  <= onehot_d;
            wcnt_q    <= wcnt_d;
            count_q   <= count_d;
            first_q   <= first_d;
            waiting_q <= waiting_d;
            done_q    <= done_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
        end
    end

    assign Stage        = stage_q;
    assign Stage_OneHot = onehot_q;
    assign Stage_First  = first_q;
    assign Waiting      = waiting_q;
    assign Instr_Done   = done_q;
    assign Instr_Count  = count_q;
    assign Halted       = halted_q;
    assign Fault        = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_sequencer
// Description : Directed self-checking bench for stage_sequencer (default
//               5-stage instance plus a 2-stage, 4-bit-count, no-timeout one).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_sequencer;

    logic        Clock = 1'b0;
    logic        Reset, Run, Step, Fetch_MFC, Mem_Access, Mem_MFC;
    logic [3:0]  Stage;
    logic [4:0]  Stage_OneHot;
    logic        Stage_First, Waiting, Instr_Done, Halted, Fault;
    logic [15:0] Instr_Count;

    logic        Run2, Fetch2;
    logic [1:0]  Stage2;
    logic [1:0]  OneHot2;
    logic        First2, Waiting2, Done2, Halted2, Fault2;
    logic [3:0]  Count2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clock = ~Clock;

    stage_sequencer u_dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .Step(Step),
        .Fetch_MFC(Fetch_MFC), .Mem_Access(Mem_Access), .Mem_MFC(Mem_MFC),
        .Stage(Stage), .Stage_OneHot(Stage_OneHot), .Stage_First(Stage_First),
        .Waiting(Waiting), .Instr_Done(Instr_Done), .Instr_Count(Instr_Count),
        .Halted(Halted), .Fault(Fault)
    );

    stage_sequencer #(
        .NUM_STAGES(2), .STAGE_W(2), .FETCH_STAGE(1), .MEM_STAGE(2),
        .MFC_TIMEOUT(0), .TMO_W(4), .COUNT_W(4)
    ) u_dut2 (
        .Clock(Clock), .Reset(Reset), .Run(Run2), .Step(1'b0),
        .Fetch_MFC(Fetch2), .Mem_Access(1'b0), .Mem_MFC(1'b1),
        .Stage(Stage2), .Stage_OneHot(OneHot2), .Stage_First(First2),
        .Waiting(Waiting2), .Instr_Done(Done2), .Instr_Count(Count2),
        .Halted(Halted2), .Fault(Fault2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Stage, its one-hot form, Stage_First and Waiting of the main instance
    task automatic chk_st(input string tag, input int st, input logic first, input logic wt);
        logic [4:0] oh;
        oh = (st == 0) ? 5'd0 : (5'd1 << (st - 1));
        check({tag, "_stage"}, 32'(Stage), 32'(st));
        check({tag, "_onehot"}, 32'(Stage_OneHot), 32'(oh));
        check({tag, "_first"}, 32'(Stage_First), 32'(first));
        check({tag, "_wait"}, 32'(Waiting), 32'(wt));
    endtask

    // Halt-after-instruction condition of the main instance
    task automatic chk_halt(input string tag, input int cnt, input logic done);
        chk_st(tag, 0, 1'b0, 1'b0);
        check({tag, "_halted"}, 32'(Halted), 32'd1);
        check({tag, "_done"}, 32'(Instr_Done), 32'(done));
        check({tag, "_count"}, 32'(Instr_Count), 32'(cnt));
        check({tag, "_fault"}, 32'(Fault), 32'd0);
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; Step = 1'b0;
        Fetch_MFC = 1'b1; Mem_Access = 1'b0; Mem_MFC = 1'b1;
        Run2 = 1'b0; Fetch2 = 1'b1;

        // ---------------- reset state
        tick(); tick();
        chk_halt("rst", 0, 1'b0);
        check("rst2_halted", 32'(Halted2), 32'd1);
        check("rst2_count", 32'(Count2), 32'd0);
        Reset = 1'b0;
        tick();
        chk_halt("idle", 0, 1'b0);

        // ---------------- continuous run, no waits
        Run = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk_st("run", (i % 5) + 1, 1'b1, 1'b0);
            check("run_done", 32'(Instr_Done), 32'((i >= 5) && (i % 5 == 0)));
            check("run_count", 32'(Instr_Count), 32'(i / 5));
            check("run_halted", 32'(Halted), 32'd0);
            tick();
        end
        chk_st("run20", 1, 1'b1, 1'b0);
        check("run20_done", 32'(Instr_Done), 32'd1);
        check("run20_count", 32'(Instr_Count), 32'd4);
        tick();
        chk_st("drop2", 2, 1'b1, 1'b0);
        Run = 1'b0;
        for (int s = 3; s <= 5; s++) begin
            tick();
            chk_st("drop", s, 1'b1, 1'b0);
        end
        tick();
        chk_halt("drophalt", 5, 1'b1);
        tick();
        chk_halt("dropidle", 5, 1'b0);

        // ---------------- single step; Step mid-instruction ignored; Run raised mid-step
        Step = 1'b1;
        tick();
        Step = 1'b0;
        chk_st("ss1", 1, 1'b1, 1'b0);
        tick();
        chk_st("ss2", 2, 1'b1, 1'b0);
        Step = 1'b1;
        tick();
        chk_st("ss3", 3, 1'b1, 1'b0);
        Step = 1'b0;
        Run = 1'b1;
        tick();
        chk_st("ss4", 4, 1'b1, 1'b0);
        tick();
        chk_st("ss5", 5, 1'b1, 1'b0);
        tick();
        chk_st("sscont", 1, 1'b1, 1'b0);
        check("sscont_done", 32'(Instr_Done), 32'd1);
        check("sscont_count", 32'(Instr_Count), 32'd6);
        Run = 1'b0;
        for (int s = 2; s <= 5; s++) begin
            tick();
            chk_st("sscont", s, 1'b1, 1'b0);
        end
        tick();
        chk_halt("sshalt", 7, 1'b1);

        // ---------------- a second plain step
        Step = 1'b1;
        tick();
        Step = 1'b0;
        chk_st("st2", 1, 1'b1, 1'b0);
        for (int s = 2; s <= 5; s++) begin
            tick();
            chk_st("st2", s, 1'b1, 1'b0);
        end
        tick();
        chk_halt("st2halt", 8, 1'b1);

        // ---------------- memory wait, Mem_MFC low for 3 cycles of stage 4
        Mem_Access = 1'b1; Mem_MFC = 1'b0;
        Step = 1'b1;
        tick();
        Step = 1'b0;
        tick(); tick(); tick();
        chk_st("mw_c3", 4, 1'b1, 1'b0);
        for (int k = 4; k <= 6; k++) begin
            tick();
            chk_st("mw_stall", 4, 1'b0, 1'b1);
        end
        Mem_MFC = 1'b1;
        tick();
        chk_st("mw_c7", 5, 1'b1, 1'b0);
        tick();
        chk_halt("mw_halt", 9, 1'b1);

        // ---------------- Mem_MFC arrives on the last allowed stall cycle
        Mem_MFC = 1'b0;
        Step = 1'b1;
        tick();
        Step = 1'b0;
        tick(); tick(); tick();
        chk_st("m8_c3", 4, 1'b1, 1'b0);
        for (int k = 4; k <= 10; k++) begin
            tick();
            chk_st("m8_stall", 4, 1'b0, 1'b1);
            check("m8_fault", 32'(Fault), 32'd0);
        end
        Mem_MFC = 1'b1;
        tick();
        chk_st("m8_adv", 5, 1'b1, 1'b0);
        check("m8_nofault", 32'(Fault), 32'd0);
        tick();
        chk_halt("m8_halt", 10, 1'b1);

        // ---------------- Mem_MFC low but no access: no wait
        Mem_Access = 1'b0; Mem_MFC = 1'b0;
        Step = 1'b1;
        tick();
        Step = 1'b0;
        tick(); tick(); tick(); tick();
        chk_st("noacc_c4", 5, 1'b1, 1'b0);
        tick();
        chk_halt("noacc_halt", 11, 1'b1);
        Mem_MFC = 1'b1;

        // ---------------- fetch timeout -> FAULT, only Reset exits
        Fetch_MFC = 1'b0;
        Run = 1'b1;
        tick();
        chk_st("tmo_c0", 1, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk_st("tmo_stall", 1, 1'b0, 1'b1);
            check("tmo_nofault", 32'(Fault), 32'd0);
        end
        tick();
        chk_st("flt", 0, 1'b0, 1'b0);
        check("flt_fault", 32'(Fault), 32'd1);
        check("flt_halted", 32'(Halted), 32'd0);
        Run = 1'b0;
        tick();
        Run = 1'b1; Step = 1'b1;
        tick();
        Step = 1'b0;
        tick();
        Fetch_MFC = 1'b1;
        tick();
        chk_st("flt_hold", 0, 1'b0, 1'b0);
        check("flt_hold_fault", 32'(Fault), 32'd1);
        check("flt_hold_halted", 32'(Halted), 32'd0);
        check("flt_hold_count", 32'(Instr_Count), 32'd11);
        Reset = 1'b1; Run = 1'b0;
        tick();
        chk_halt("flt_rst", 0, 1'b0);
        Reset = 1'b0;

        // ---------------- reset in stage 3 clears the count
        Run = 1'b1;
        tick();
        for (int k = 1; k <= 7; k++) tick();
        chk_st("rs3", 3, 1'b1, 1'b0);
        check("rs3_count", 32'(Instr_Count), 32'd1);
        Reset = 1'b1;
        tick();
        chk_halt("rs3_rst", 0, 1'b0);
        Reset = 1'b0; Run = 1'b0;
        tick();

        // ---------------- 2-stage instance: count wrap and disabled timeout
        Run2 = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            check("w_stage", 32'(Stage2), 32'((i % 2) + 1));
            check("w_count", 32'(Count2), 32'(i / 2));
            tick();
        end
        check("w_wrap_stage", 32'(Stage2), 32'd1);
        check("w_wrap_done", 32'(Done2), 32'd1);
        check("w_wrap_count", 32'(Count2), 32'd0);
        Fetch2 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("w_stall_stage", 32'(Stage2), 32'd1);
            check("w_stall_wait", 32'(Waiting2), 32'd1);
            check("w_stall_fault", 32'(Fault2), 32'd0);
        end
        Fetch2 = 1'b1; Run2 = 1'b0;
        tick();
        check("w_adv_stage", 32'(Stage2), 32'd2);
        check("w_adv_onehot", 32'(OneHot2), 32'd2);
        tick();
        check("w_end_halted", 32'(Halted2), 32'd1);
        check("w_end_done", 32'(Done2), 32'd1);
        check("w_end_count", 32'(Count2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
